// File: rtl/dco_tune_seq.sv
// Slew-limited sequencer that walks the DCO thermometer bank toward a requested tuning code.
// Build option: define DCO_TUNE_SLEW_EN for one-LSB stepping; otherwise each request is a single jump.
module dco_tune_seq #(
    parameter int unsigned W          = 6,
    parameter int unsigned SETTLE     = 3,
    parameter int unsigned RESET_CODE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [W-1:0]        req_code,
    output logic [W-1:0]        cur_code,
    output logic [(1<<W)-2:0]   therm,
    output logic                busy,
    output logic                done
);

    localparam int unsigned NB       = (1 << W) - 1;
    localparam logic [W-1:0] RST_CODE = W'(RESET_CODE);
    localparam logic [7:0]   CNT_LOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

    state_t       state, state_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic [W-1:0] tgt, tgt_nxt, cur_nxt;
    logic         eq_hit, eq_nxt, done_nxt;

    function automatic logic [NB-1:0] therm_of(input logic [W-1:0] code);
        logic [NB-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            t[i] = (i < 32'(code));
        end
        return t;
    endfunction

    assign req_ready = (state == IDLE);

    // Next-state, settle counter and code update; eq_hit delays the D=0 done by one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        cur_nxt   = cur_code;
        eq_nxt    = 1'b0;
        done_nxt  = eq_hit;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    tgt_nxt = req_code;
                    if (req_code == cur_code) begin
                        eq_nxt = 1'b1;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            STEP: begin
`ifdef DCO_TUNE_SLEW_EN
                cur_nxt = (tgt > cur_code) ? cur_code + W'(1) : cur_code - W'(1);
`else
                cur_nxt = tgt;
`endif
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (cur_code == tgt) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = STEP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // therm is derived from cur_nxt so both update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            tgt      <= RST_CODE;
            cur_code <= RST_CODE;
            therm    <= therm_of(RST_CODE);
            busy     <= 1'b0;
            done     <= 1'b0;
            eq_hit   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tgt      <= tgt_nxt;
            cur_code <= cur_nxt;
            therm    <= therm_of(cur_nxt);
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            eq_hit   <= eq_nxt;
        end
    end

endmodule

// File: tb/tb_dco_tune_seq.sv
// Directed bench for dco_tune_seq: two instances (SETTLE=3 and SETTLE=1) checked against a cycle model.
// Expected trajectories follow DCO_TUNE_SLEW_EN the same way the design does.
module tb_dco_tune_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv  [2];
    logic [5:0]  rc  [2];
    logic        rdy [2];
    logic [5:0]  cur [2];
    logic [62:0] th  [2];
    logic        bsy [2];
    logic        dn  [2];

    int checks = 0;
    int errors = 0;
    int mc [2];
    int st [2];

    always #5 clk = ~clk;

    dco_tune_seq #(.W(6), .SETTLE(3), .RESET_CODE(32)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_code(rc[0]),
        .cur_code(cur[0]), .therm(th[0]), .busy(bsy[0]), .done(dn[0])
    );

    dco_tune_seq #(.W(6), .SETTLE(1), .RESET_CODE(32)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_code(rc[1]),
        .cur_code(cur[1]), .therm(th[1]), .busy(bsy[1]), .done(dn[1])
    );

    function automatic logic [63:0] thermo(input int c);
        return (64'd1 << c) - 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input int u, input string tag, input int ecur, input bit ebusy, input bit edone);
        chk({tag, "_cur"},   64'(cur[u]), 64'(ecur));
        chk({tag, "_therm"}, 64'(th[u]),  thermo(ecur));
        chk({tag, "_busy"},  64'(bsy[u]), 64'(ebusy));
        chk({tag, "_ready"}, 64'(rdy[u]), 64'(!ebusy));
        chk({tag, "_done"},  64'(dn[u]),  64'(edone));
    endtask

    // One request on unit u; pre = request already on the bus, noise = hold valid with code 10 while busy.
    task automatic seq(input int u, input int code, input bit pre, input bit noise);
        int start, d, s, total, stp, ec;
        logic [62:0] prev;
        start = mc[u];
        s     = st[u];
        d     = (code > start) ? code - start : start - code;
        if (!pre) begin
            @(negedge clk);
            rv[u] = 1'b1;
            rc[u] = 6'(code);
        end
        @(posedge clk);
        #1;
        if (noise) begin
            rv[u] = 1'b1;
            rc[u] = 6'd10;
        end else begin
            rv[u] = 1'b0;
        end
        check_out(u, $sformatf("u%0d_to%0d_acc", u, code), start, d != 0, 1'b0);
        if (d == 0) begin
            total = 1;
        end else begin
`ifdef DCO_TUNE_SLEW_EN
            total = d * (s + 1);
`else
            total = s + 1;
`endif
        end
        prev = th[u];
        for (int t = 1; t <= total + (noise ? 0 : 1); t++) begin
            @(posedge clk);
            #1;
`ifdef DCO_TUNE_SLEW_EN
            stp = (t - 1) / (s + 1) + 1;
            if (stp > d) stp = d;
            ec = (code > start) ? start + stp : start - stp;
            chk($sformatf("u%0d_to%0d_t%0d_onebit", u, code, t), 64'($countones(th[u] ^ prev) <= 1), 64'd1);
`else
            ec = code;
`endif
            check_out(u, $sformatf("u%0d_to%0d_t%0d", u, code, t), ec, (d != 0) && (t < total), t == total);
            prev = th[u];
        end
        mc[u] = code;
    endtask

    initial begin
        st[0] = 3;
        st[1] = 1;
        mc[0] = 32;
        mc[1] = 32;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rc[0] = 6'd0;
        rc[1] = 6'd0;
        rst   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_out(0, "reset_u0", 32, 1'b0, 1'b0);
        check_out(1, "reset_u1", 32, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Upward walk, equal-code request, downward walk with a competing request held during busy.
        seq(0, 37, 1'b0, 1'b0);
        seq(0, 37, 1'b0, 1'b0);
        seq(0, 34, 1'b0, 1'b1);
        seq(0, 10, 1'b1, 1'b0);

        // Reset asserted mid-sequence, between clock edges.
        @(negedge clk);
        rv[0] = 1'b1;
        rc[0] = 6'd50;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_out(0, "rst_mid_u0", 32, 1'b0, 1'b0);
        check_out(1, "rst_mid_u1", 32, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mc[0] = 32;
        mc[1] = 32;

        // Range boundaries with SETTLE=1.
        seq(1, 2, 1'b0, 1'b0);
        seq(1, 0, 1'b0, 1'b0);
        seq(1, 62, 1'b0, 1'b0);
        seq(1, 63, 1'b0, 1'b0);
        seq(1, 63, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
